pipelined_addsub: RTL and testbench

PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

---
 rtl/pipelined_addsub_pkg.sv | 8 +
 rtl/add_chunk.sv | 14 +
 rtl/pipelined_addsub.sv | 94 +++++++++
 tb/tb_pipelined_addsub.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_addsub_pkg.sv
// pipelined_addsub_pkg: mode constants and parameter legality check shared by the add/sub pipeline.
package pipelined_addsub_pkg;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
  function automatic bit addsub_legal(int width, int stages);
    return width >= 4 && width <= 128 && stages >= 1 && stages <= width && width % stages == 0;
  endfunction
endpackage

// File: rtl/add_chunk.sv
// add_chunk: combinational C-bit adder slice exposing the carry into its MSB for overflow detection.
module add_chunk #(
  parameter int C = 8
) (
  input  logic [C-1:0] a,
  input  logic [C-1:0] b,
  input  logic         ci,
  output logic [C-1:0] s,
  output logic         co,
  output logic         cm
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{C{1'b0}}, ci};
  assign cm = s[C-1] ^ a[C-1] ^ b[C-1];
endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: carry-chained adder/subtractor split into STAGES chunk stages with
// operand skew and result de-skew, valid/ready handshake, whole-pipe stall.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int C = WIDTH / STAGES;
  logic w_en;
  if (!addsub_legal(WIDTH, STAGES)) begin : g_bad_params
    $error("pipelined_addsub: illegal WIDTH=%0d STAGES=%0d", WIDTH, STAGES);
  end
  assign w_en = !out_valid | out_ready;
  assign in_ready = w_en;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int UW = WIDTH - k * C;
    logic [UW-1:0] w_a, w_b;
    logic [C-1:0] w_s;
    logic [(k+1)*C-1:0] w_s_next, r_s;
    logic w_vi, w_ci, w_co, w_cm, r_v, r_c;
    if (k == 0) begin : g_src
      assign w_a = a;
      assign w_b = (sub == MODE_ADD) ? b : ~b;
      assign w_ci = (sub == MODE_SUB) ? 1'b1 : cin;
      assign w_vi = in_valid;
      assign w_s_next = w_s;
    end else begin : g_src
      assign w_a = g_st[k-1].g_fwd.r_a;
      assign w_b = g_st[k-1].g_fwd.r_b;
      assign w_ci = g_st[k-1].r_c;
      assign w_vi = g_st[k-1].r_v;
      assign w_s_next = {w_s, g_st[k-1].r_s};
    end
    add_chunk #(.C(C)) u_add (
      .a(w_a[C-1:0]),
      .b(w_b[C-1:0]),
      .ci(w_ci),
      .s(w_s),
      .co(w_co),
      .cm(w_cm)
    );
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_s <= '0;
      end else if (w_en) begin
        r_v <= w_vi;
        r_c <= w_co;
        r_s <= w_s_next;
      end
    end
    // Upper operand chunks still waiting for their stage travel alongside the partial result.
    if (k < STAGES - 1) begin : g_fwd
      logic [UW-C-1:0] r_a, r_b;
      logic w_unused_cm;
      assign w_unused_cm = w_cm;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_en) begin
          r_a <= w_a[UW-1:C];
          r_b <= w_b[UW-1:C];
        end
      end
    end else begin : g_out
      logic r_o;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_o <= 1'b0;
        else if (w_en) r_o <= w_co ^ w_cm;
      end
    end
  end
  assign out_valid = g_st[STAGES-1].r_v;
  assign sum = g_st[STAGES-1].r_s;
  assign cout = g_st[STAGES-1].r_c;
  assign ovf = g_st[STAGES-1].g_out.r_o;
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: scoreboard bench for the pipelined adder/subtractor.
module tb_pipelined_addsub;
  localparam int W = 8;
  localparam int S = 4;
  typedef struct {logic [7:0] s; logic co; logic ov; int t; bit lat;} exp_t;
  typedef struct packed {logic [7:0] x; logic [7:0] y; logic c; logic sb; logic [7:0] s; logic co; logic ov;} vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, cin = 1'b0, sub = 1'b0, out_ready = 1'b1;
  logic [W-1:0] a = '0, b = '0, sum;
  logic in_ready, out_valid, cout, ovf;
  logic iv32 = 1'b0;
  logic [31:0] a32 = '0, s1, s32;
  logic ir1, ov1, co1, of1, ir32, ov32, co32, of32;
  exp_t q[$];
  vec_t tv[12];
  int checks = 0, errors = 0, cyc = 0, n_out = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf));
  pipelined_addsub #(.WIDTH(32), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir1), .a(a32), .b(32'd1), .cin(1'b1), .sub(1'b0),
    .out_valid(ov1), .out_ready(1'b1), .sum(s1), .cout(co1), .ovf(of1));
  pipelined_addsub #(.WIDTH(32), .STAGES(32)) u_s32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(32'd1), .cin(1'b1), .sub(1'b0),
    .out_valid(ov32), .out_ready(1'b1), .sum(s32), .cout(co32), .ovf(of32));

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic exp_t model(logic [7:0] x, logic [7:0] y, logic c, logic sb);
    exp_t r;
    logic [8:0] f;
    logic [7:0] lo, yy;
    logic ci;
    yy = sb ? ~y : y;
    ci = sb ? 1'b1 : c;
    f = {1'b0, x} + {1'b0, yy} + {8'd0, ci};
    lo = {1'b0, x[6:0]} + {1'b0, yy[6:0]} + {7'd0, ci};
    r.s = f[7:0];
    r.co = f[8];
    r.ov = lo[7] ^ f[8];
    r.t = 0;
    r.lat = 1'b0;
    return r;
  endfunction

  function automatic exp_t from_vec(vec_t v);
    exp_t r;
    r.s = v.s;
    r.co = v.co;
    r.ov = v.ov;
    r.t = 0;
    r.lat = 1'b0;
    return r;
  endfunction

  task automatic send(logic [7:0] x, logic [7:0] y, logic c, logic sb, exp_t e, bit lat);
    int n = 0;
    a = x; b = y; cin = c; sub = sb; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", {31'd0, in_ready}, 32'd1);
    else begin
      e.t = cyc;
      e.lat = lat;
      q.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (q.size() == 0) chk("unexpected_result", {22'd0, sum, cout, ovf}, 32'hFFFF_FFFF);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("result{sum,cout,ovf}", {22'd0, sum, cout, ovf}, {22'd0, e.s, e.co, e.ov});
        if (e.lat) chk("latency", cyc - e.t, S);
      end
    end
  end

  initial begin
    int n0, l1, l32, t0;
    exp_t e;
    logic [7:0] x, y;
    logic c, sb;
    tv = '{
      '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0},
      '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1},
      '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0},
      '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1},
      '{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0},
      '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1},
      '{8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0},
      '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0},
      '{8'h7F, 8'h80, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1},
      '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0},
      '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0},
      '{8'h55, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0}};
    #12;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_outputs", {22'd0, sum, cout, ovf}, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) send(tv[i].x, tv[i].y, tv[i].c, tv[i].sb, from_vec(tv[i]), 1'b1);
    for (int i = 0; i < 16; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      c = 1'($urandom);
      sb = 1'($urandom);
      send(x, y, c, sb, model(x, y, c, sb), 1'b1);
    end
    drain();
    chk("stream_count", n_out, 32'd28);
    n0 = n_out;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(tv[i].x, tv[i].y, tv[i].c, tv[i].sb, from_vec(tv[i]), 1'b0);
    a = 8'h55; b = 8'h11; cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_frozen", {22'd0, sum, cout, ovf}, {22'd0, tv[0].s, tv[0].co, tv[0].ov});
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(8'h55, 8'h11, 1'b0, 1'b1, model(8'h55, 8'h11, 1'b0, 1'b1), 1'b0);
    drain();
    chk("stall_count", n_out - n0, 32'd5);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(tv[i].x, tv[i].y, tv[i].c, tv[i].sb, from_vec(tv[i]), 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("pre_reset_out_valid", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("async_reset_outputs", {22'd0, sum, cout, ovf}, 32'd0);
    q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    n0 = n_out;
    send(tv[4].x, tv[4].y, tv[4].c, tv[4].sb, from_vec(tv[4]), 1'b1);
    drain();
    chk("post_reset_count", n_out - n0, 32'd1);
    l1 = -1;
    l32 = -1;
    a32 = 32'h7FFF_FFFF;
    iv32 = 1'b1;
    @(negedge clk);
    t0 = cyc;
    chk("w32_in_ready", {30'd0, ir1, ir32}, 32'd3);
    @(posedge clk);
    #1 iv32 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ov1 && l1 < 0) begin
        l1 = cyc - t0;
        chk("w32_s1_result", s1, 32'h8000_0001);
        chk("w32_s1_flags", {30'd0, co1, of1}, 32'd1);
      end
      if (ov32 && l32 < 0) begin
        l32 = cyc - t0;
        chk("w32_s32_result", s32, 32'h8000_0001);
        chk("w32_s32_flags", {30'd0, co32, of32}, 32'd1);
      end
    end
    chk("w32_s1_latency", l1, 32'd1);
    chk("w32_s32_latency", l32, 32'd32);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
